// File: rtl/field_packer_if.sv
// field_packer_if: field-in / packed-word-out handshake bundle for field_packer
interface field_packer_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 8,
  parameter int CNT_W = $clog2(OUT_W / IN_W) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_last;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/field_packer.sv
// field_packer: packs IN_W-bit fields MSB-first into OUT_W-bit words with early close on in_last
module field_packer #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 8,
  parameter int CNT_W = $clog2(OUT_W / IN_W) + 1
) (
  input logic           clk,
  input logic           rst,
  field_packer_if.slave bus
);
  localparam int NUM = OUT_W / IN_W;
  localparam int IDX_W = $clog2(NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  if (OUT_W % IN_W != 0 || NUM < 2 || IN_W < 1) begin : g_bad_params
    $error("field_packer: OUT_W must be a multiple of IN_W with at least two fields");
  end
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] ins;
  logic [IDX_W-1:0] idx;
  logic             take;
  logic             done;
  always_comb begin
    ins = acc;
    ins[OUT_W-1-int'(idx)*IN_W -: IN_W] = bus.in_data;
  end
  assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready);
  assign take = bus.in_valid && bus.in_ready;
  assign done = idx == LAST_IDX || bus.in_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      idx           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_count <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (take && done) begin
        bus.out_data  <= ins;
        bus.out_count <= CNT_W'(idx) + CNT_W'(1);
        bus.out_last  <= bus.in_last;
        bus.out_valid <= 1'b1;
        acc           <= '0;
        idx           <= '0;
      end else if (take) begin
        acc <= ins;
        idx <= idx + IDX_W'(1);
      end
    end
  end
  a_count_nonzero: assert property (@(posedge clk) disable iff (rst) bus.out_valid |-> bus.out_count != '0);
endmodule

// File: tb/tb_field_packer.sv
// tb_field_packer: directed stimulus with a queue scoreboard and a decoupled output monitor
module tb_field_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  typedef struct packed {
    logic [7:0] data;
    logic [2:0] count;
    logic       last;
  } exp_t;
  exp_t exp_q[$];
  int vtimes[$];
  logic       prev_rst = 1'b1;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = '0;
  logic [2:0] prev_c = '0;
  logic       prev_l = 1'b0;
  field_packer_if #(.IN_W(2), .OUT_W(8), .CNT_W(3)) bus ();
  field_packer #(.IN_W(2), .OUT_W(8), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !prev_rst) begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, prev_d);
        chk("hold_count", bus.out_count, prev_c);
        chk("hold_last", bus.out_last, prev_l);
      end else if (!bus.out_valid) begin
        chk("idle_data", bus.out_data, prev_d);
        chk("idle_count", bus.out_count, prev_c);
        chk("idle_last", bus.out_last, prev_l);
      end
    end
    if (!rst && bus.out_valid) begin
      vtimes.push_back(cyc);
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", bus.out_data, 0);
          chk("unexpected_word_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", bus.out_data, e.data);
          chk("word_count", bus.out_count, e.count);
          chk("word_last", bus.out_last, e.last);
        end
      end
    end
    prev_rst = rst;
    prev_v = bus.out_valid;
    prev_r = bus.out_ready;
    prev_d = bus.out_data;
    prev_c = bus.out_count;
    prev_l = bus.out_last;
  end
  task automatic expect_word(input logic [7:0] d, input logic [2:0] c, input logic l);
    exp_q.push_back('{data: d, count: c, last: l});
  endtask
  task automatic send(input logic [1:0] d, input logic l, output int w);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int w;
    int wsum;
    logic [1:0] f5[12];
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_last", bus.out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    wsum = 0;
    expect_word(8'hE4, 3'd4, 1'b0);
    send(2'b11, 1'b0, w); wsum += w;
    send(2'b10, 1'b0, w); wsum += w;
    send(2'b01, 1'b0, w); wsum += w;
    send(2'b00, 1'b0, w); wsum += w;
    chk("t1_no_stall", wsum, 0);
    @(negedge clk);
    chk("t1_latency_valid", bus.out_valid, 1);
    idle(2);
    expect_word(8'h90, 3'd2, 1'b1);
    send(2'b10, 1'b0, w);
    send(2'b01, 1'b1, w);
    idle(2);
    expect_word(8'hC0, 3'd1, 1'b1);
    send(2'b11, 1'b1, w);
    idle(2);
    bus.out_ready = 1'b0;
    expect_word(8'hE4, 3'd4, 1'b0);
    send(2'b11, 1'b0, w);
    send(2'b10, 1'b0, w);
    send(2'b01, 1'b0, w);
    send(2'b00, 1'b0, w);
    bus.in_valid = 1'b1;
    bus.in_data = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_bp_in_ready", bus.in_ready, 0);
      chk("t4_bp_data", bus.out_data, 8'hE4);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    expect_word(8'h6C, 3'd4, 1'b0);
    send(2'b01, 1'b0, w);
    send(2'b10, 1'b0, w);
    send(2'b11, 1'b0, w);
    send(2'b00, 1'b0, w);
    idle(2);
    f5 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10};
    expect_word(8'h1B, 3'd4, 1'b0);
    expect_word(8'hFF, 3'd4, 1'b0);
    expect_word(8'h42, 3'd4, 1'b0);
    vtimes.delete();
    wsum = 0;
    for (int i = 0; i < 12; i++) begin
      send(f5[i], 1'b0, w);
      wsum += w;
    end
    idle(3);
    chk("t5_no_stall", wsum, 0);
    chk("t5_word_cycles", vtimes.size(), 3);
    if (vtimes.size() == 3) begin
      chk("t5_gap01", vtimes[1] - vtimes[0], 4);
      chk("t5_gap12", vtimes[2] - vtimes[1], 4);
    end
    send(2'b11, 1'b0, w);
    send(2'b01, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_data", bus.out_data, 0);
    chk("t6_rst_count", bus.out_count, 0);
    chk("t6_rst_last", bus.out_last, 0);
    rst = 1'b0;
    exp_q.delete();
    expect_word(8'h01, 3'd4, 1'b0);
    send(2'b00, 1'b0, w);
    send(2'b00, 1'b0, w);
    send(2'b00, 1'b0, w);
    send(2'b01, 1'b0, w);
    idle(2);
    bus.out_ready = 1'b0;
    send(2'b11, 1'b0, w);
    send(2'b11, 1'b0, w);
    send(2'b00, 1'b0, w);
    send(2'b00, 1'b0, w);
    idle(2);
    @(negedge clk);
    chk("t6_hold_valid", bus.out_valid, 1);
    chk("t6_hold_data", bus.out_data, 8'hF0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_hrst_valid", bus.out_valid, 0);
    chk("t6_hrst_data", bus.out_data, 0);
    chk("t6_hrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    expect_word(8'hAA, 3'd4, 1'b0);
    send(2'b10, 1'b0, w);
    send(2'b10, 1'b0, w);
    send(2'b10, 1'b0, w);
    send(2'b10, 1'b0, w);
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
